// File: rtl/hash_arbiter_if.sv
// Hash unit side of the arbiter: level start plus latched key out,
// sticky ready plus hash value back.
interface hash_arbiter_if #(
    parameter int KEY_W = 64,
    parameter int VAL_W = 32
);
    logic             hash_start;
    logic [KEY_W-1:0] hash_key;
    logic             hash_ready;
    logic [VAL_W-1:0] hash_val;

    modport master (
        output hash_start,
        output hash_key,
        input  hash_ready,
        input  hash_val
    );

    modport slave (
        input  hash_start,
        input  hash_key,
        output hash_ready,
        output hash_val
    );
endinterface

// File: rtl/hash_arbiter.sv
// Round-robin arbiter sharing one multi-cycle hash unit between
// NUM_REQ key builders, with hang timeout and id-tagged responses.
module hash_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int KEY_W   = 64,
    parameter int VAL_W   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_i,
    input  logic [NUM_REQ*KEY_W-1:0] key_i,
    output logic [NUM_REQ-1:0]       grant_o,
    output logic                     resp_valid_o,
    output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] resp_id_o,
    output logic [VAL_W-1:0]         resp_hash_o,
    output logic                     resp_err_o,
    output logic                     busy_o,
    hash_arbiter_if.master           hif
);
    localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_RELEASE
    } state_t;

    state_t             r_state, w_state;
    logic [ID_W-1:0]    r_rr, w_rr;
    logic [ID_W-1:0]    r_id, w_id;
    logic [KEY_W-1:0]   r_key, w_key;
    logic               r_start, w_start;
    logic [CNT_W-1:0]   r_cnt, w_cnt;
    logic [NUM_REQ-1:0] r_grant, w_grant;
    logic               r_rvalid, w_rvalid;
    logic [ID_W-1:0]    r_rid, w_rid;
    logic [VAL_W-1:0]   r_rhash, w_rhash;
    logic               r_rerr, w_rerr;
    logic               r_busy, w_busy;

    logic               w_found;
    logic [ID_W-1:0]    w_pick;
    logic [ID_W:0]      w_scan;
    logic [ID_W:0]      w_inc;

    // Round-robin scan starting at r_rr, plus the pointer after the pick
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_scan  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_scan = {1'b0, r_rr} + (ID_W+1)'(i);
            if (w_scan >= (ID_W+1)'(NUM_REQ))
                w_scan = w_scan - (ID_W+1)'(NUM_REQ);
            if (!w_found && req_i[w_scan[ID_W-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_scan[ID_W-1:0];
            end
        end
        w_inc = {1'b0, w_pick} + (ID_W+1)'(1);
        if (w_inc >= (ID_W+1)'(NUM_REQ))
            w_inc = '0;
    end

    // Next-state and next-output logic of the handshake sequencer
    always_comb begin
        w_state  = r_state;
        w_rr     = r_rr;
        w_id     = r_id;
        w_key    = r_key;
        w_start  = r_start;
        w_cnt    = r_cnt;
        w_grant  = '0;
        w_rvalid = 1'b0;
        w_rid    = r_rid;
        w_rhash  = r_rhash;
        w_rerr   = r_rerr;
        unique case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state = S_START;
                    w_grant = NUM_REQ'(1) << w_pick;
                    w_key   = key_i[w_pick*KEY_W +: KEY_W];
                    w_id    = w_pick;
                    w_rr    = w_inc[ID_W-1:0];
                end
            end
            S_START: begin
                w_start = 1'b1;
                w_cnt   = '0;
                w_state = S_WAIT;
            end
            S_WAIT: begin
                if (r_cnt != '1)
                    w_cnt = r_cnt + CNT_W'(1);
                // ready is stale from the last op until the unit sees start
                if (hif.hash_ready && r_cnt >= CNT_W'(2)) begin
                    w_rvalid = 1'b1;
                    w_rid    = r_id;
                    w_rhash  = hif.hash_val;
                    w_rerr   = 1'b0;
                    w_start  = 1'b0;
                    w_state  = S_RELEASE;
                end else if (r_cnt == CNT_W'(TIMEOUT-1)) begin
                    w_rvalid = 1'b1;
                    w_rid    = r_id;
                    w_rhash  = '0;
                    w_rerr   = 1'b1;
                    w_start  = 1'b0;
                    w_state  = S_RELEASE;
                end
            end
            S_RELEASE: begin
                w_state = S_IDLE;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
        w_busy = (w_state != S_IDLE);
    end

    // State and registered outputs, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_rr     <= '0;
            r_id     <= '0;
            r_key    <= '0;
            r_start  <= 1'b0;
            r_cnt    <= '0;
            r_grant  <= '0;
            r_rvalid <= 1'b0;
            r_rid    <= '0;
            r_rhash  <= '0;
            r_rerr   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_rr     <= w_rr;
            r_id     <= w_id;
            r_key    <= w_key;
            r_start  <= w_start;
            r_cnt    <= w_cnt;
            r_grant  <= w_grant;
            r_rvalid <= w_rvalid;
            r_rid    <= w_rid;
            r_rhash  <= w_rhash;
            r_rerr   <= w_rerr;
            r_busy   <= w_busy;
        end
    end

    assign grant_o        = r_grant;
    assign resp_valid_o   = r_rvalid;
    assign resp_id_o      = r_rid;
    assign resp_hash_o    = r_rhash;
    assign resp_err_o     = r_rerr;
    assign busy_o         = r_busy;
    assign hif.hash_start = r_start;
    assign hif.hash_key   = r_key;
endmodule
